// File: rtl/branch_target_buffer_pkg.sv
// branch_target_buffer_pkg: shared CACHE_BRANCH entry, BTB FSM states and MEM-to-fetch update bundle.
package branch_target_buffer_pkg;
  localparam int CB_TAG_W = 6;
  typedef struct packed {
    logic                v;
    logic [CB_TAG_W-1:0] tag;
    logic [31:0]         ta;
    logic                t;
  } CACHE_BRANCH;
  typedef enum logic {BTB_SWEEP, BTB_READY} BTB_FSM_Enum;
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } BTB_UPD_struct;
endpackage

// File: rtl/btb_counter2.sv
// btb_counter2: 2-bit saturating counter step (up on taken, down on not-taken).
module btb_counter2 (
  input  logic [1:0] ctr_i,
  input  logic       inc_i,
  output logic [1:0] ctr_o
);
  always_comb ctr_o = inc_i ? ((ctr_i == 2'b11) ? ctr_i : ctr_i + 2'b01)
                            : ((ctr_i == 2'b00) ? ctr_i : ctr_i - 2'b01);
endmodule

// File: rtl/branch_target_buffer.sv
// branch_target_buffer: fetch-stage BTB with post-reset/flush sweep; BTB_2BIT_CTR_EN adds 2-bit counters.
module branch_target_buffer
  import branch_target_buffer_pkg::*;
#(
  parameter int IDX_W = 4,
  parameter int TAG_W = CB_TAG_W
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] lk_pc,
  output logic        lk_hit,
  output logic        lk_taken,
  output logic [31:0] lk_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        flush,
  output logic        busy
);
  localparam int DEPTH = 1 << IDX_W;
  CACHE_BRANCH      tbl_q [DEPTH];
  CACHE_BRANCH      tbl_d [DEPTH];
  BTB_FSM_Enum      state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  BTB_UPD_struct    upd;
  CACHE_BRANCH      lk_e, u_e;
  logic [IDX_W-1:0] lk_idx, u_idx;
  logic [TAG_W-1:0] lk_tag, u_tag;
  logic             ready, u_hit, lk_t;
  logic             unused_bits;
  assign upd    = '{valid: upd_valid, pc: upd_pc, taken: upd_taken, target: upd_target};
  assign lk_idx = lk_pc[IDX_W+1:2];
  assign lk_tag = lk_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign u_idx  = upd.pc[IDX_W+1:2];
  assign u_tag  = upd.pc[IDX_W+TAG_W+1:IDX_W+2];
  assign lk_e   = tbl_q[lk_idx];
  assign u_e    = tbl_q[u_idx];
  // Gating with rst_n keeps stale V bits invisible during the reset cycle too
  assign ready     = rst_n && state_q == BTB_READY;
  assign busy      = !ready;
  assign u_hit     = u_e.v && u_e.tag == u_tag;
  assign lk_hit    = ready && lk_e.v && lk_e.tag == lk_tag;
  assign lk_taken  = lk_hit && lk_t;
  assign lk_target = lk_hit ? lk_e.ta : '0;
`ifdef BTB_2BIT_CTR_EN
  logic [1:0] ctr_q [DEPTH];
  logic [1:0] ctr_d [DEPTH];
  logic [1:0] ctr_nxt;
  btb_counter2 u_ctr (.ctr_i(ctr_q[u_idx]), .inc_i(upd.taken), .ctr_o(ctr_nxt));
  assign lk_t = ctr_q[lk_idx][1];
  assign unused_bits = ^{lk_pc[31:IDX_W+TAG_W+2], lk_pc[1:0], upd.pc[31:IDX_W+TAG_W+2], upd.pc[1:0], u_e.t, u_e.ta, lk_e.t};
  always_ff @(posedge clk) ctr_q <= ctr_d;
`else
  assign lk_t = lk_e.t;
  assign unused_bits = ^{lk_pc[31:IDX_W+TAG_W+2], lk_pc[1:0], upd.pc[31:IDX_W+TAG_W+2], upd.pc[1:0], u_e.t, u_e.ta};
`endif
  always_comb begin
    tbl_d   = tbl_q;
    state_d = state_q;
    cnt_d   = cnt_q;
`ifdef BTB_2BIT_CTR_EN
    ctr_d   = ctr_q;
`endif
    if (state_q == BTB_SWEEP) begin
      tbl_d[cnt_q].v = 1'b0;
      cnt_d = flush ? '0 : cnt_q + IDX_W'(1);
      if (!flush && &cnt_q) state_d = BTB_READY;
    end else if (flush) begin
      state_d = BTB_SWEEP;
      cnt_d   = '0;
    end else if (upd.valid && (u_hit || upd.taken)) begin
      // Not-taken misses fall out above: they are never allocated
      if (upd.taken) tbl_d[u_idx] = '{v: 1'b1, tag: u_tag, ta: upd.target, t: 1'b1};
      else tbl_d[u_idx].t = 1'b0;
`ifdef BTB_2BIT_CTR_EN
      ctr_d[u_idx] = u_hit ? ctr_nxt : 2'b10;
`endif
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= BTB_SWEEP;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  always_ff @(posedge clk) tbl_q <= tbl_d;
endmodule

// File: tb/tb_branch_target_buffer.sv
// tb_branch_target_buffer: table-driven vectors with a scoreboard queue for branch_target_buffer.
module tb_branch_target_buffer;
  logic        clk = 1'b0;
  logic        rst_n, upd_valid, upd_taken, flush;
  logic [31:0] lk_pc, upd_pc, upd_target;
  logic        lk_hit, lk_taken, busy;
  logic [31:0] lk_target;
  int          n_tests = 0;
  int          n_fail  = 0;

  typedef struct {
    logic        rst_n, flush, uv;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utg, lk;
    logic        busy, hit, tk;
    logic [31:0] tgt;
  } vec_t;

  logic [34:0] sb [$];
  vec_t        tbl [$];

  branch_target_buffer dut (
    .clk(clk), .rst_n(rst_n), .lk_pc(lk_pc), .lk_hit(lk_hit), .lk_taken(lk_taken),
    .lk_target(lk_target), .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .flush(flush), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic f, input logic uv, input logic [31:0] upc,
                              input logic ut, input logic [31:0] utg, input logic [31:0] lk,
                              input logic b, input logic h, input logic tk, input logic [31:0] tgt);
    vec_t v;
    v.rst_n = r; v.flush = f; v.uv = uv; v.upc = upc; v.ut = ut; v.utg = utg; v.lk = lk;
    v.busy = b; v.hit = h; v.tk = tk; v.tgt = tgt;
    return v;
  endfunction

  // Drives one cycle of stimulus at the negedge and checks the pre-edge lookup
  task automatic apply(input vec_t v, input string name);
    logic [34:0] got, exp;
    rst_n = v.rst_n; flush = v.flush; upd_valid = v.uv; upd_pc = v.upc;
    upd_taken = v.ut; upd_target = v.utg; lk_pc = v.lk;
    sb.push_back({v.busy, v.hit, v.tk, v.tgt});
    #1;
    got = {busy, lk_hit, lk_taken, lk_target};
    exp = sb.pop_front();
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s lk_pc=%h: busy/hit/taken/target got %b/%b/%b/%h expected %b/%b/%b/%h",
               name, v.lk, got[34], got[33], got[32], got[31:0], exp[34], exp[33], exp[32], exp[31:0]);
    end
    @(negedge clk);
  endtask

  task automatic sweep(input int n, input string name);
    for (int i = 0; i < n; i++)
      apply(mk(1, 0, 1, 32'h48, 1, 32'h999, 32'h40 + 32'(i * 4), 1, 0, 0, 0), $sformatf("%s_%0d", name, i));
  endtask

  initial begin
    apply(mk(0, 0, 0, 0, 0, 0, 32'h40, 1, 0, 0, 0), "reset_0");
    apply(mk(0, 0, 0, 0, 0, 0, 32'h40, 1, 0, 0, 0), "reset_1");
    sweep(16, "init_sweep");
    tbl.push_back(mk(1, 0, 1, 32'h40,  1, 32'h100, 32'h40,   0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0,       0, 0,       32'h40,   0, 1, 1, 32'h100));
    tbl.push_back(mk(1, 0, 0, 0,       0, 0,       32'h1040, 0, 1, 1, 32'h100));
    tbl.push_back(mk(1, 0, 0, 0,       0, 0,       32'h840,  0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0,       0, 0,       32'h48,   0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 32'h40,  0, 0,       32'h40,   0, 1, 1, 32'h100));
    tbl.push_back(mk(1, 0, 0, 0,       0, 0,       32'h40,   0, 1, 0, 32'h100));
    tbl.push_back(mk(1, 0, 1, 32'h80,  0, 0,       32'h80,   0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0,       0, 0,       32'h80,   0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0,       0, 0,       32'h40,   0, 1, 0, 32'h100));
    tbl.push_back(mk(1, 0, 1, 32'h840, 1, 32'h200, 32'h840,  0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0,       0, 0,       32'h840,  0, 1, 1, 32'h200));
    tbl.push_back(mk(1, 0, 0, 0,       0, 0,       32'h40,   0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 32'h44,  1, 32'h300, 32'h44,   0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0,       0, 0,       32'h47,   0, 1, 1, 32'h300));
    foreach (tbl[i]) apply(tbl[i], $sformatf("vec_%0d", i));
`ifdef BTB_2BIT_CTR_EN
    apply(mk(1, 0, 1, 32'h100, 1, 32'h500, 32'h100, 0, 0, 0, 0),        "ctr_alloc");
    apply(mk(1, 0, 1, 32'h100, 0, 0,       32'h100, 0, 1, 1, 32'h500), "ctr_10");
    apply(mk(1, 0, 1, 32'h100, 1, 32'h500, 32'h100, 0, 1, 0, 32'h500), "ctr_01");
    apply(mk(1, 0, 1, 32'h100, 1, 32'h500, 32'h100, 0, 1, 1, 32'h500), "ctr_10b");
    apply(mk(1, 0, 1, 32'h100, 1, 32'h500, 32'h100, 0, 1, 1, 32'h500), "ctr_11");
    apply(mk(1, 0, 1, 32'h100, 0, 0,       32'h100, 0, 1, 1, 32'h500), "ctr_11_sat");
    apply(mk(1, 0, 1, 32'h100, 0, 0,       32'h100, 0, 1, 1, 32'h500), "ctr_10c");
    apply(mk(1, 0, 0, 0,       0, 0,       32'h100, 0, 1, 0, 32'h500), "ctr_01_final");
`endif
    apply(mk(1, 1, 1, 32'hC0, 1, 32'h400, 32'h44, 0, 1, 1, 32'h300), "flush_with_upd");
    sweep(5, "flush_sweep");
    apply(mk(1, 1, 0, 0, 0, 0, 32'h44, 1, 0, 0, 0), "flush_mid_sweep");
    sweep(16, "restart_sweep");
    apply(mk(1, 0, 0, 0, 0, 0, 32'h44,  0, 0, 0, 0), "post_flush_44");
    apply(mk(1, 0, 0, 0, 0, 0, 32'hC0,  0, 0, 0, 0), "post_flush_c0");
    apply(mk(1, 0, 0, 0, 0, 0, 32'h840, 0, 0, 0, 0), "post_flush_840");
    apply(mk(1, 0, 1, 32'h40, 1, 32'h100, 32'h40, 0, 0, 0, 0), "realloc_40");
    apply(mk(1, 0, 0, 0, 0, 0, 32'h40, 0, 1, 1, 32'h100), "realloc_40_hit");
    apply(mk(0, 0, 0, 0, 0, 0, 32'h40, 1, 0, 0, 0), "mid_op_reset");
    sweep(16, "reset_sweep");
    apply(mk(1, 0, 0, 0, 0, 0, 32'h40, 0, 0, 0, 0), "post_reset_40");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
